soc_io_bridge: RTL and testbench

- Sits between the Processor memory port and the Memory block.
- Address space is split by one address bit:
  - IO_BIT=0: requests pass through to RAM.
  - IO_BIT=1: requests go to a parametrised IO page.
- IO page contains:
  - LED register, LED_W bits wide.
  - Buffered UART transmitter with a FIFO of FIFO_DEPTH entries.
  - Free-running 32-bit cycle counter.
- Replaces the direct debug-to-LED wiring with software-visible, memory-mapped peripherals.

---
 rtl/soc_pkg.sv | 22 ++
 rtl/soc_uart_tx.sv | 142 ++++++++++++++
 rtl/soc_io_bridge.sv | 98 +++++++++
 tb/tb_soc_io_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared definitions for the SoC IO bridge: register offsets, status bit
// positions and the UART serializer state encoding.
package soc_pkg;

    localparam logic [1:0] REG_LEDS        = 2'd0;
    localparam logic [1:0] REG_UART_DATA   = 2'd1;
    localparam logic [1:0] REG_UART_STATUS = 2'd2;
    localparam logic [1:0] REG_CYCLES      = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/soc_uart_tx.sv
// Buffered 8N1 UART transmitter: circular TX FIFO, sticky overflow flag and
// a start/data/stop serializer with a registered output.
module soc_uart_tx
    import soc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       clr_ovf,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic       uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    uart_state_t   r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_pop, w_push_ok, w_baud_last;

    assign full      = (r_cnt == CW'(FIFO_DEPTH));
    assign empty     = (r_cnt == '0);
    assign busy      = (r_state != UART_IDLE);
    assign ovf       = r_ovf;
    assign uart_tx   = r_tx;
    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for the push.
    assign w_push_ok = push & ~full;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (push && full) r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign w_baud_last = (r_baud == BW'(BAUD_DIV - 1));

    // The line level is computed for the state being entered, so uart_tx
    // changes on the same edge as the state register.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + BW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            UART_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_state_nxt = UART_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            UART_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = UART_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            UART_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            UART_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = UART_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/soc_io_bridge.sv
// CPU-to-memory bridge: one address bit splits traffic between RAM and an IO
// page holding LEDs, a buffered UART transmitter and a cycle counter.
module soc_io_bridge
    import soc_pkg::*;
#(
    parameter int IO_BIT     = 22,
    parameter int LED_W      = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic             mem_rstrb,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic [31:0]      mem_rdata,
    output logic             ram_rstrb,
    output logic [3:0]       ram_wmask,
    input  logic [31:0]      ram_rdata,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);

    logic             w_io;
    logic [1:0]       w_off;
    logic             w_led_we, w_push, w_clr_ovf;
    logic             w_full, w_empty, w_busy, w_ovf;
    logic [31:0]      w_io_rval;
    logic [LED_W-1:0] r_leds;
    logic [31:0]      r_cycles;
    logic             r_io_sel;
    logic [31:0]      r_io_rdata;
    logic             w_unused;

    assign w_io      = mem_addr[IO_BIT];
    assign w_off     = mem_addr[3:2];
    assign ram_rstrb = mem_rstrb & ~w_io;
    assign ram_wmask = w_io ? 4'b0000 : mem_wmask;
    assign w_led_we  = w_io && (w_off == REG_LEDS);
    assign w_push    = w_io && (w_off == REG_UART_DATA) && mem_wmask[0];
    assign w_clr_ovf = w_io && (w_off == REG_UART_STATUS) && mem_wmask[0] && mem_wdata[3];
    assign w_unused  = &{1'b0, mem_addr, mem_wdata};

    soc_uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_DIV   (BAUD_DIV)
    ) u_uart (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (mem_wdata[7:0]),
        .clr_ovf   (w_clr_ovf),
        .full      (w_full),
        .empty     (w_empty),
        .busy      (w_busy),
        .ovf       (w_ovf),
        .uart_tx   (uart_tx)
    );

    always_comb begin
        w_io_rval = '0;
        case (w_off)
            REG_LEDS:        w_io_rval = 32'(r_leds);
            REG_UART_STATUS: begin
                w_io_rval[ST_FULL]  = w_full;
                w_io_rval[ST_EMPTY] = w_empty;
                w_io_rval[ST_BUSY]  = w_busy;
                w_io_rval[ST_OVF]   = w_ovf;
            end
            REG_CYCLES:      w_io_rval = r_cycles;
            default:         w_io_rval = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds     <= '0;
            r_cycles   <= '0;
            r_io_sel   <= 1'b0;
            r_io_rdata <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            // LED bit i lives in byte lane i/8.
            for (int i = 0; i < LED_W; i++) begin
                if (w_led_we && mem_wmask[i/8]) r_leds[i] <= mem_wdata[i];
            end
            if (mem_rstrb) begin
                r_io_sel   <= w_io;
                r_io_rdata <= w_io_rval;
            end
        end
    end

    assign leds      = r_leds;
    assign mem_rdata = r_io_sel ? r_io_rdata : ram_rdata;

endmodule

// File: tb/tb_soc_io_bridge.sv
// Randomized and directed bench for soc_io_bridge against a transaction-level
// model of the IO page (byte queue, frame timer, register values).
module tb_soc_io_bridge;

    localparam int D = 4;
    localparam int B = 4;
    localparam int LW = 5;

    logic          clk, rst;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata, ram_rdata;
    logic          mem_rstrb, ram_rstrb, uart_tx;
    logic [3:0]    mem_wmask, ram_wmask;
    logic [LW-1:0] leds;

    soc_io_bridge #(.IO_BIT(22), .LED_W(LW), .FIFO_DEPTH(D), .BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .ram_rstrb(ram_rstrb), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
        .leds(leds), .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the bridge: 1-cycle read latency, byte-masked writes.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (ram_rstrb) ram_rdata <= ram[mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (ram_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    int n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_leds, m_cyc, m_iord;
    logic        m_iosel, m_ovf, m_known;
    logic [7:0]  m_cur;
    logic [7:0]  q [$];
    int          m_frm;

    logic [31:0] s_rdata;
    logic        s_tx, s_rs;
    logic [3:0]  s_wm;
    logic [LW-1:0] s_leds;

    function automatic logic [31:0] m_status();
        logic [31:0] v;
        v = '0;
        v[0] = (q.size() == D);
        v[1] = (q.size() == 0);
        v[2] = (m_frm > 0);
        v[3] = m_ovf;
        return v;
    endfunction

    // Expected line level from the position inside the 10-slot frame.
    function automatic logic m_tx();
        int p, slot;
        if (m_frm == 0) return 1'b1;
        p = 10*B - m_frm;
        slot = p / B;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    function automatic logic [31:0] m_rval(input logic [1:0] off);
        case (off)
            2'd0:    return m_leds;
            2'd2:    return m_status();
            2'd3:    return m_cyc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_update(input logic r, input logic [31:0] a, input logic rs,
                            input logic [31:0] wd, input logic [3:0] wm);
        logic io, full0, pop, push, clr;
        logic [1:0] off;
        logic [31:0] rv;
        if (r) begin
            m_leds = 0; m_cyc = 0; m_iord = 0; m_iosel = 0; m_ovf = 0;
            m_frm = 0; q.delete(); m_known = 1;
            return;
        end
        io = a[22]; off = a[3:2];
        rv = m_rval(off);
        full0 = (q.size() == D);
        pop = (m_frm == 0) && (q.size() > 0);
        push = io && off == 2'd1 && wm[0];
        clr = io && off == 2'd2 && wm[0] && wd[3];
        if (rs) begin m_iosel = io; m_iord = rv; end
        if (io && off == 2'd0)
            for (int i = 0; i < LW; i++) if (wm[i/8]) m_leds[i] = wd[i];
        m_cyc = m_cyc + 1;
        if (pop) begin m_cur = q.pop_front(); m_frm = 10*B; end
        else if (m_frm > 0) m_frm--;
        if (push && !full0) q.push_back(wd[7:0]);
        if (push && full0) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic rs,
                        input logic [31:0] wd, input logic [3:0] wm);
        logic eio;
        rst = r; mem_addr = a; mem_rstrb = rs; mem_wdata = wd; mem_wmask = wm;
        @(negedge clk);
        s_rdata = mem_rdata; s_tx = uart_tx; s_rs = ram_rstrb; s_wm = ram_wmask; s_leds = leds;
        if (m_known) begin
            eio = a[22];
            chk("ram_rstrb", ram_rstrb, rs & ~eio);
            chk("ram_wmask", ram_wmask, eio ? 4'h0 : wm);
            chk("leds", leds, m_leds);
            chk("uart_tx", uart_tx, m_tx());
            chk("mem_rdata", mem_rdata, m_iosel ? m_iord : ram_rdata);
        end
        @(posedge clk);
        m_update(r, a, rs, wd, wm);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    localparam logic [31:0] A_LED = 32'h0040_0000;
    localparam logic [31:0] A_TXD = 32'h0040_0004;
    localparam logic [31:0] A_STA = 32'h0040_0008;
    localparam logic [31:0] A_CYC = 32'h0040_000C;

    initial begin
        int busy_n;
        logic [31:0] v1, v2, a;
        n_chk = 0; n_fail = 0; m_known = 0;
        rst = 1; mem_addr = 0; mem_rstrb = 0; mem_wdata = 0; mem_wmask = 0; ram_rdata = 0;
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        step(1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
        step(1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
        chk("rst_tx", s_tx, 1'b1);
        chk("rst_leds", 32'(s_leds), 32'h0);
        idle(2);

        // LED write/read
        step(1'b0, A_LED, 1'b0, 32'hFFFF_FFFF, 4'hF);
        chk("led_ram_wm", 32'(s_wm), 32'h0);
        step(1'b0, A_LED, 1'b1, 32'h0, 4'h0);
        chk("led_val", 32'(s_leds), 32'h1F);
        idle(1);
        chk("led_rd", s_rdata, 32'h1F);

        // RAM passthrough and IO/RAM back to back
        step(1'b0, 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
        chk("ram_wm", 32'(s_wm), 32'hF);
        step(1'b0, 32'h10, 1'b1, 32'h0, 4'h0);
        chk("ram_rs", 32'(s_rs), 32'h1);
        idle(1);
        chk("ram_rd", s_rdata, 32'hDEAD_BEEF);
        step(1'b0, A_LED, 1'b1, 32'h0, 4'h0);
        step(1'b0, 32'h10, 1'b1, 32'h0, 4'h0);
        chk("b2b_io", s_rdata, 32'h1F);
        idle(1);
        chk("b2b_ram", s_rdata, 32'hDEAD_BEEF);

        // Cycle counter: reads 10 cycles apart
        step(1'b0, A_CYC, 1'b1, 32'h0, 4'h0);
        idle(1);
        v1 = s_rdata;
        idle(8);
        step(1'b0, A_CYC, 1'b1, 32'h0, 4'h0);
        idle(1);
        v2 = s_rdata;
        chk("cyc_diff", v2 - v1, 32'd10);

        // Single byte 0x55: busy for exactly 40 cycles
        step(1'b0, A_TXD, 1'b0, 32'h55, 4'h1);
        busy_n = 0;
        for (int j = 1; j <= 50; j++) begin
            step(1'b0, A_STA, 1'b1, 32'h0, 4'h0);
            if (j >= 2 && s_rdata[2]) busy_n++;
        end
        chk("busy_len", busy_n, 40);
        chk("st_empty", s_rdata, 32'h2);

        // Overflow: push 01..06 back to back
        for (int k = 1; k <= 6; k++) step(1'b0, A_TXD, 1'b0, k, 4'h1);
        step(1'b0, A_STA, 1'b1, 32'h0, 4'h0);
        idle(1);
        chk("st_ovf", s_rdata, 32'hD);
        step(1'b0, A_STA, 1'b0, 32'h8, 4'h1);
        step(1'b0, A_STA, 1'b1, 32'h0, 4'h0);
        idle(1);
        chk("st_clr", s_rdata & 32'h8, 32'h0);
        idle(5*41 + 10);

        // Reset during DATA bit 3 with two bytes still queued
        for (int k = 0; k < 3; k++) step(1'b0, A_TXD, 1'b0, 32'hA5 + k, 4'h1);
        idle(16);
        step(1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
        step(1'b0, A_CYC, 1'b1, 32'h0, 4'h0);
        chk("mrst_tx", s_tx, 1'b1);
        chk("mrst_leds", 32'(s_leds), 32'h0);
        step(1'b0, A_STA, 1'b1, 32'h0, 4'h0);
        chk("mrst_cyc", s_rdata, 32'h0);
        idle(1);
        chk("mrst_st", s_rdata, 32'h2);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                step(1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
            end else begin
                if ($urandom_range(0, 1) == 1)
                    a = 32'h0040_0000 | ($urandom & 32'h003F_FFF0) | (32'($urandom_range(0, 3)) << 2);
                else
                    a = $urandom & 32'h0000_00FF;
                step(1'b0, a, 1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
            end
        end
        idle(D*41 + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
